l2_mem_arbiter: RTL
===================

// Module: l2_mem_arbiter
// PURPOSE
//  Shares the single word-wide memory port between NUM_REQ requesters (L2 miss/fill path, L2
//  write-back path, further clients). Round-robin arbitration, one outstanding memory access,
//  optional burst lock so that a cache-block fill or write-back completes without interleaving.
//  Sits between the L2 cache's memory-side port and the memory controller.
// PARAMETERS
//  NUM_REQ        2    number of requesters (>=2)
//  DATA_WIDTH     32   memory word width
//  ADDR_WIDTH     32   memory address width
//  BURST_LEN      4    max words per locked burst (BLOCK_SIZE 16 bytes / 4-byte words)
//  TIMEOUT_CYCLES 255  mem_ready watchdog limit (used only with MEM_ARB_TIMEOUT_EN)
// PORTS
//  clk          in   1                   clock
//  rst_n        in   1                   asynchronous active-low reset
//  req_addr     in   NUM_REQ*ADDR_WIDTH  per-requester address, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  req_wdata    in   NUM_REQ*DATA_WIDTH  per-requester write data, same packing
//  req_read     in   NUM_REQ             read request, held until req_ready
//  req_write    in   NUM_REQ             write request, held until req_ready
//  req_lock     in   NUM_REQ             keep grant after this access (burst)
//  req_rdata    out  DATA_WIDTH          read data, valid while req_ready is high; broadcast to all
//  req_ready    out  NUM_REQ             one-cycle completion pulse for the granted requester
//  grant        out  NUM_REQ             one-hot current owner; 0 when idle
//  timeout_err  out  1                   pulses with req_ready on watchdog abort
//  mem_addr     out  ADDR_WIDTH          to memory
//  mem_data_out out  DATA_WIDTH          to memory (write data)
//  mem_data_in  in   DATA_WIDTH          from memory (read data)
//  mem_read     out  1                   memory read strobe, held until mem_ready
//  mem_write    out  1                   memory write strobe, held until mem_ready
//  mem_ready    in   1                   memory completion, sampled only while a strobe is high
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; rr pointer 0; beat counter 0; lock released.
//    Reset mid-access abandons the memory cycle; strobes drop asynchronously.
//  - States: IDLE -> BUSY -> RESP -> IDLE. All outputs are registered.
//  - IDLE: requester i is active when req_read[i]|req_write[i]. If a lock is held, only the
//    owner is eligible. Otherwise the first active index at or after the pointer (wrapping) wins.
//    Latch the winner's addr, wdata and op; set grant; go to BUSY.
//  - Read and write both high on one requester is illegal; the arbiter treats it as a write.
//  - BUSY: mem_read or mem_write is high and mem_addr/mem_data_out are stable.
//    On the mem_ready cycle: capture mem_data_in (reads), drop strobes, go to RESP.
//  - RESP: req_ready[g]=1 for exactly one cycle; req_rdata holds the captured word (0 for writes).
//    The requester updates or drops its request at the same clock edge.
//  - Lock: if req_lock[g] is high in RESP and beats < BURST_LEN, hold grant and lock.
//    Otherwise clear lock and grant and set pointer = (g+1) mod NUM_REQ.
//    The beat counter counts completed accesses under one lock and clears on release.
//  - Latency: request visible in IDLE at cycle N -> strobe at N+1. mem_ready at cycle M ->
//    req_ready at M+1. Minimum back-to-back spacing is 3 cycles per access.
//  - Under lock, if the owner has no active request in IDLE, the arbiter waits one cycle and then
//    releases the lock (no deadlock).
// CONFIGURATION
//  - MEM_ARB_TIMEOUT_EN defined: a counter runs in BUSY. If TIMEOUT_CYCLES cycles pass without
//    mem_ready, drop strobes and go to RESP with req_rdata=0 and timeout_err=1; the lock is released.
//  - MEM_ARB_TIMEOUT_EN undefined: BUSY waits indefinitely; timeout_err is tied 0; no counter is built.
// STRUCTURE
//  - Package l2_mem_arb_pkg: state enum (IDLE, BUSY, RESP), op encoding (OP_RD, OP_WR),
//    function for the wrap-around one-hot round-robin pick.
//  - Sub-module rr_pick: combinational (active vector, pointer, lock mask) -> one-hot winner.
//    The FSM, latches and counters stay in the top level.
// TESTING
//  1. Single read: req_read[0]=1, addr 0x100, mem_ready after 2 cycles with data 0xDEADBEEF
//     -> mem_read 1 cycle after request; req_ready[0] and rdata 0xDEADBEEF 1 cycle after mem_ready.
//  2. Contention: req 0 and req 1 read simultaneously, pointer 0 -> grant order 0,1,0,1.
//     No req_ready[1] before req_ready[0].
//  3. Burst: req 1 writes 4 words with req_lock=1 while req 0 is pending -> 4 consecutive grants
//     to req 1, then req 0. A 5th locked beat is forced to release after BURST_LEN.
//  4. Reset mid-BUSY: rst_n low with mem_read high -> all outputs 0 immediately; a fresh request
//     after reset is granted to the lowest active index.
//  5. Timeout (macro on, TIMEOUT_CYCLES=8): mem_ready never asserted -> strobe drops after 8 BUSY
//     cycles; req_ready and timeout_err pulse together; rdata=0.
//  6. Read+write both high on requester 0 -> mem_write issued, mem_read stays 0.

Source files
------------

// File: rtl/l2_mem_arbiter_pkg.sv
// Shared types and the wrap-around round-robin pick used by the L2 memory-port arbiter.
package l2_mem_arb_pkg;

    localparam int MAX_REQ = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } arb_op_e;

    // First active index at or after ptr, wrapping at n; result is one-hot (or zero).
    function automatic logic [MAX_REQ-1:0] rr_onehot(input logic [MAX_REQ-1:0] active,
                                                     input int unsigned ptr,
                                                     input int unsigned n);
        logic [MAX_REQ-1:0] pick;
        logic               found;
        int unsigned        idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = ptr + k;
            if (idx >= n) begin
                idx = idx - n;
            end else begin
                idx = idx;
            end
            if ((k < n) && !found && active[idx[4:0]]) begin
                pick[idx[4:0]] = 1'b1;
                found          = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/l2_mem_arbiter_rr_pick.sv
// Combinational round-robin winner select: active requests, rotate pointer, lock mask -> one-hot.
module rr_pick
    import l2_mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] active,
    input  logic [NUM_REQ-1:0] lock_mask,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] winner
);

    logic [MAX_REQ-1:0] pad_s;
    logic [MAX_REQ-1:0] pick_s;

    // Widen the masked request vector to the package width and pick.
    always_comb begin
        pad_s                = '0;
        pad_s[NUM_REQ-1:0]   = active & lock_mask;
        pick_s               = rr_onehot(pad_s, 32'(ptr), 32'(NUM_REQ));
        winner               = pick_s[NUM_REQ-1:0];
    end

endmodule

// File: rtl/l2_mem_arbiter.sv
// Round-robin arbiter sharing one word-wide memory port among NUM_REQ L2 requesters, with burst lock.
// Optional mem_ready watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module l2_mem_arbiter
    import l2_mem_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int BURST_LEN      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]            req_read,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ-1:0]            req_lock,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          timeout_err,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_data_out,
    input  logic [DATA_WIDTH-1:0]         mem_data_in,
    output logic                          mem_read,
    output logic                          mem_write,
    input  logic                          mem_ready
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW = $clog2(BURST_LEN + 1);

    arb_state_e              state_r, state_n;
    arb_op_e                 op_r, op_n;
    logic [NUM_REQ-1:0]      grant_r, grant_n;
    logic [NUM_REQ-1:0]      ready_r, ready_n;
    logic [PW-1:0]           ptr_r, ptr_n;
    logic [BW-1:0]           beats_r, beats_n;
    logic                    lock_r, lock_n;
    logic                    lock_wait_r, lock_wait_n;
    logic [ADDR_WIDTH-1:0]   addr_r, addr_n;
    logic [DATA_WIDTH-1:0]   wdata_r, wdata_n;
    logic [DATA_WIDTH-1:0]   rdata_r, rdata_n;
    logic                    mem_read_r, mem_read_n;
    logic                    mem_write_r, mem_write_n;

    logic [NUM_REQ-1:0]      active_s;
    logic [NUM_REQ-1:0]      lock_mask_s;
    logic [NUM_REQ-1:0]      win_s;
    logic [ADDR_WIDTH-1:0]   win_addr_s;
    logic [DATA_WIDTH-1:0]   win_wdata_s;
    logic                    win_wr_s;
    logic [PW-1:0]           gidx_s;
    logic [PW-1:0]           next_ptr_s;
    logic                    keep_lock_s;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]           tmo_cnt_r, tmo_cnt_n;
    logic                    tmo_r, tmo_n;
`endif

    assign active_s    = req_read | req_write;
    assign lock_mask_s = lock_r ? grant_r : {NUM_REQ{1'b1}};

    rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr_pick (
        .active    (active_s),
        .lock_mask (lock_mask_s),
        .ptr       (ptr_r),
        .winner    (win_s)
    );

    // Winner's request fields, and the encoded index of the current owner.
    always_comb begin
        win_addr_s  = '0;
        win_wdata_s = '0;
        win_wr_s    = 1'b0;
        gidx_s      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_addr_s  = win_addr_s  | (req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{win_s[i]}});
            win_wdata_s = win_wdata_s | (req_wdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{win_s[i]}});
            win_wr_s    = win_wr_s | (req_write[i] & win_s[i]);
            if (grant_r[i]) begin
                gidx_s = PW'(i);
            end else begin
                gidx_s = gidx_s;
            end
        end
        next_ptr_s = (gidx_s == PW'(NUM_REQ - 1)) ? '0 : (gidx_s + PW'(1));
    end

    // Burst continues only while the owner asks for it, the beat budget remains and no abort occurred.
    always_comb begin
        keep_lock_s = (|(req_lock & grant_r)) && ((int'(beats_r) + 1) < BURST_LEN);
`ifdef MEM_ARB_TIMEOUT_EN
        keep_lock_s = keep_lock_s && !tmo_r;
`endif
    end

    // Next-state and registered-output logic of the IDLE/BUSY/RESP controller.
    always_comb begin
        state_n     = state_r;
        op_n        = op_r;
        grant_n     = grant_r;
        ready_n     = '0;
        ptr_n       = ptr_r;
        beats_n     = beats_r;
        lock_n      = lock_r;
        lock_wait_n = lock_wait_r;
        addr_n      = addr_r;
        wdata_n     = wdata_r;
        rdata_n     = rdata_r;
        mem_read_n  = mem_read_r;
        mem_write_n = mem_write_r;
`ifdef MEM_ARB_TIMEOUT_EN
        tmo_cnt_n   = tmo_cnt_r;
        tmo_n       = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (|win_s) begin
                    grant_n     = win_s;
                    addr_n      = win_addr_s;
                    wdata_n     = win_wdata_s;
                    op_n        = win_wr_s ? OP_WR : OP_RD;
                    mem_write_n = win_wr_s;
                    mem_read_n  = !win_wr_s;
                    lock_wait_n = 1'b0;
                    state_n     = BUSY;
                end else if (lock_r) begin
                    // Owner went quiet under lock: give it one cycle, then let others in.
                    if (lock_wait_r) begin
                        lock_n      = 1'b0;
                        lock_wait_n = 1'b0;
                        grant_n     = '0;
                        beats_n     = '0;
                        ptr_n       = next_ptr_s;
                    end else begin
                        lock_wait_n = 1'b1;
                    end
                end else begin
                    lock_wait_n = 1'b0;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    rdata_n     = (op_r == OP_RD) ? mem_data_in : '0;
                    mem_read_n  = 1'b0;
                    mem_write_n = 1'b0;
                    ready_n     = grant_r;
                    state_n     = RESP;
                end else begin
`ifdef MEM_ARB_TIMEOUT_EN
                    if (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
                        rdata_n     = '0;
                        mem_read_n  = 1'b0;
                        mem_write_n = 1'b0;
                        ready_n     = grant_r;
                        tmo_n       = 1'b1;
                        state_n     = RESP;
                    end else begin
                        tmo_cnt_n = tmo_cnt_r + TW'(1);
                    end
`else
                    state_n = BUSY;
`endif
                end
            end
            RESP: begin
                rdata_n     = '0;
                lock_wait_n = 1'b0;
                state_n     = IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
                tmo_cnt_n   = '0;
`endif
                if (keep_lock_s) begin
                    lock_n  = 1'b1;
                    beats_n = beats_r + BW'(1);
                end else begin
                    lock_n  = 1'b0;
                    beats_n = '0;
                    grant_n = '0;
                    ptr_n   = next_ptr_s;
                end
            end
            default: begin
                state_n     = IDLE;
                grant_n     = '0;
                lock_n      = 1'b0;
                beats_n     = '0;
                mem_read_n  = 1'b0;
                mem_write_n = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any memory cycle in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            op_r        <= OP_RD;
            grant_r     <= '0;
            ready_r     <= '0;
            ptr_r       <= '0;
            beats_r     <= '0;
            lock_r      <= 1'b0;
            lock_wait_r <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= '0;
            rdata_r     <= '0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            op_r        <= op_n;
            grant_r     <= grant_n;
            ready_r     <= ready_n;
            ptr_r       <= ptr_n;
            beats_r     <= beats_n;
            lock_r      <= lock_n;
            lock_wait_r <= lock_wait_n;
            addr_r      <= addr_n;
            wdata_r     <= wdata_n;
            rdata_r     <= rdata_n;
            mem_read_r  <= mem_read_n;
            mem_write_r <= mem_write_n;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog counter and abort flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_r <= '0;
            tmo_r     <= 1'b0;
        end else begin
            tmo_cnt_r <= tmo_cnt_n;
            tmo_r     <= tmo_n;
        end
    end
    assign timeout_err = tmo_r;
`else
    assign timeout_err = 1'b0;
`endif

    assign grant        = grant_r;
    assign req_ready    = ready_r;
    assign req_rdata    = rdata_r;
    assign mem_addr     = addr_r;
    assign mem_data_out = wdata_r;
    assign mem_read     = mem_read_r;
    assign mem_write    = mem_write_r;

endmodule
